hold_hlda_arbiter: RTL and testbench

- Shares the 8088 system bus between the processor and N_REQ external bus masters (DMA-style engines) using the 8088 HOLD/HLDA handshake.
- Selects one requester round-robin and raises HOLD to the processor.
- Issues a one-hot grant after HLDA is seen.
- Bounds each grant's tenure, then returns the bus to the processor.
- Sits beside the Intel8088 processor on the shared pin interface; its HOLD output drives the processor HOLD pin, and HLDA is fed back from the processor.

---
 rtl/intel8088_bus_pkg.sv | 9 +
 rtl/hold_hlda_arbiter_if.sv | 8 +
 rtl/rr_pick.sv | 22 ++
 rtl/hold_hlda_arbiter.sv | 97 +++++++++
 tb/tb_hold_hlda_arbiter.sv | 154 +++++++++++++++
 5 files changed

// File: rtl/intel8088_bus_pkg.sv
// intel8088_bus_pkg: arbiter state encoding, default tenure/timeout limits and index-to-one-hot helper
package intel8088_bus_pkg;
  typedef enum logic [1:0] {IDLE, REQUEST, GRANTED, RELEASE} arb_state_t;
  localparam int DEF_MAX_TENURE = 16;
  localparam int DEF_HLDA_TIMEOUT = 64;
  function automatic logic [7:0] idx2oh(input logic [2:0] idx);
    return 8'b1 << idx;
  endfunction
endpackage

// File: rtl/hold_hlda_arbiter_if.sv
// hold_hlda_arbiter_if: bus-master side (req/done/hlda) to arbiter side (hold/gnt/owner/busy/err) signal bundle
interface hold_hlda_arbiter_if #(parameter int N_REQ = 4, parameter int IDX_W = $clog2(N_REQ));
  logic [N_REQ-1:0] req, done, gnt;
  logic hlda, hold, busy, err;
  logic [IDX_W-1:0] owner;
  modport master(output req, done, hlda, input hold, gnt, owner, busy, err);
  modport slave(input req, done, hlda, output hold, gnt, owner, busy, err);
endinterface

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin picker; req/ptr in, found/winner out (first set bit at or after ptr, wrapping)
module rr_pick #(
  parameter int N_REQ = 4,
  parameter int IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic             found,
  output logic [IDX_W-1:0] winner
);
  logic [IDX_W:0] s;
  always_comb begin
    found = |req;
    winner = '0;
    s = '0;
    for (int i = N_REQ-1; i >= 0; i--) begin
      s = {1'b0, ptr} + (IDX_W+1)'(i);
      s = (s >= (IDX_W+1)'(N_REQ)) ? s - (IDX_W+1)'(N_REQ) : s;
      winner = req[s[IDX_W-1:0]] ? s[IDX_W-1:0] : winner;
    end
  end
endmodule

// File: rtl/hold_hlda_arbiter.sv
// hold_hlda_arbiter: 8088 HOLD/HLDA bus arbiter; CLK/RESET plain, bus.slave carries req/done/hlda in and hold/gnt/owner/busy/err out
module hold_hlda_arbiter import intel8088_bus_pkg::*; #(
  parameter int N_REQ = 4,
  parameter int MAX_TENURE = DEF_MAX_TENURE,
  parameter int HLDA_TIMEOUT = DEF_HLDA_TIMEOUT,
  parameter int IDX_W = $clog2(N_REQ)
) (
  input logic CLK,
  input logic RESET,
  hold_hlda_arbiter_if.slave bus
);
  localparam int TEN_W = $clog2(MAX_TENURE+1);
  localparam int TO_W = $clog2(HLDA_TIMEOUT+1);
  arb_state_t state_q, state_d;
  logic [IDX_W-1:0] owner_q, owner_d, ptr_q, ptr_d, winner;
  logic [TEN_W-1:0] ten_q, ten_d;
  logic [TO_W-1:0] to_q, to_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic hold_q, hold_d, err_q, err_d, busy_q, found;
  rr_pick #(.N_REQ(N_REQ), .IDX_W(IDX_W)) u_pick (.req(bus.req), .ptr(ptr_q), .found(found), .winner(winner));
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    ptr_d = ptr_q;
    ten_d = ten_q;
    to_d = to_q;
    hold_d = hold_q;
    gnt_d = gnt_q;
    err_d = 1'b0;
    case (state_q)
      IDLE: if (found) begin
        state_d = REQUEST;
        owner_d = winner;
        hold_d = 1'b1;
        to_d = '0;
      end
      REQUEST: begin
        to_d = to_q + 1'b1;
        if (bus.hlda) begin
          state_d = bus.req[owner_q] ? GRANTED : RELEASE;
          gnt_d = bus.req[owner_q] ? N_REQ'(idx2oh(3'(owner_q))) : '0;
          hold_d = bus.req[owner_q];
          ten_d = '0;
        end else if (to_q == TO_W'(HLDA_TIMEOUT-1)) begin
          state_d = RELEASE;
          hold_d = 1'b0;
          err_d = 1'b1;
        end
      end
      GRANTED: begin
        ten_d = ten_q + 1'b1;
        if (!bus.hlda || bus.done[owner_q] || !bus.req[owner_q] || ten_q == TEN_W'(MAX_TENURE-1)) begin
          state_d = RELEASE;
          gnt_d = '0;
          hold_d = 1'b0;
          err_d = !bus.hlda;
        end
      end
      RELEASE: begin
        hold_d = 1'b0;
        if (!bus.hlda) begin
          state_d = IDLE;
          ptr_d = (owner_q == IDX_W'(N_REQ-1)) ? '0 : owner_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= IDLE;
      owner_q <= '0;
      ptr_q <= '0;
      ten_q <= '0;
      to_q <= '0;
      gnt_q <= '0;
      hold_q <= 1'b0;
      err_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q <= ptr_d;
      ten_q <= ten_d;
      to_q <= to_d;
      gnt_q <= gnt_d;
      hold_q <= hold_d;
      err_q <= err_d;
      busy_q <= state_d != IDLE;
    end
  end
  assign bus.hold = hold_q;
  assign bus.gnt = gnt_q;
  assign bus.owner = owner_q;
  assign bus.busy = busy_q;
  assign bus.err = err_q;
endmodule

// File: tb/tb_hold_hlda_arbiter.sv
// tb_hold_hlda_arbiter: directed vector table plus hand-written sequences for the HOLD/HLDA arbiter
module tb_hold_hlda_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errs = 0;
  hold_hlda_arbiter_if #(.N_REQ(4)) bus();
  hold_hlda_arbiter #(.N_REQ(4), .MAX_TENURE(16), .HLDA_TIMEOUT(64)) dut(.CLK(clk), .RESET(rst), .bus(bus));
  always #5 clk = ~clk;
  typedef struct {
    logic [3:0] req;
    logic [3:0] done;
    logic hlda;
    logic hold;
    logic [3:0] gnt;
    logic [1:0] owner;
    logic busy;
  } vec_t;
  vec_t tbl[17];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic grant_cycle(input logic [1:0] exp);
    logic [3:0] oh;
    oh = 4'b0001 << exp;
    step(1);
    chk($sformatf("rr_req%0d", exp), {bus.hold, bus.owner, bus.gnt}, {1'b1, exp, 4'b0000});
    bus.hlda = 1'b1;
    step(1);
    chk($sformatf("rr_gnt%0d", exp), {bus.gnt, bus.owner}, {oh, exp});
    bus.done = oh;
    step(1);
    bus.done = 4'b0000;
    chk($sformatf("rr_done%0d", exp), {bus.gnt, bus.hold}, 5'b0);
    bus.hlda = 1'b0;
    step(1);
    chk($sformatf("rr_idle%0d", exp), {bus.busy, bus.hold, bus.gnt}, 6'b0);
  endtask
  initial begin
    int cnt;
    logic gnt_seen;
    bus.req = '0;
    bus.done = '0;
    bus.hlda = 1'b0;
    tbl[0]  = '{4'b0001, 4'b0000, 1'b0, 1'b1, 4'b0000, 2'd0, 1'b1};
    tbl[1]  = '{4'b0001, 4'b0000, 1'b0, 1'b1, 4'b0000, 2'd0, 1'b1};
    tbl[2]  = '{4'b0001, 4'b0000, 1'b0, 1'b1, 4'b0000, 2'd0, 1'b1};
    tbl[3]  = '{4'b0001, 4'b0000, 1'b1, 1'b1, 4'b0001, 2'd0, 1'b1};
    tbl[4]  = '{4'b0001, 4'b0000, 1'b1, 1'b1, 4'b0001, 2'd0, 1'b1};
    tbl[5]  = '{4'b0001, 4'b0010, 1'b1, 1'b1, 4'b0001, 2'd0, 1'b1};
    tbl[6]  = '{4'b0001, 4'b0000, 1'b1, 1'b1, 4'b0001, 2'd0, 1'b1};
    tbl[7]  = '{4'b0001, 4'b0000, 1'b1, 1'b1, 4'b0001, 2'd0, 1'b1};
    tbl[8]  = '{4'b0001, 4'b0001, 1'b1, 1'b0, 4'b0000, 2'd0, 1'b1};
    tbl[9]  = '{4'b0000, 4'b0000, 1'b1, 1'b0, 4'b0000, 2'd0, 1'b1};
    tbl[10] = '{4'b0000, 4'b0000, 1'b0, 1'b0, 4'b0000, 2'd0, 1'b0};
    tbl[11] = '{4'b0011, 4'b0000, 1'b0, 1'b1, 4'b0000, 2'd1, 1'b1};
    tbl[12] = '{4'b0000, 4'b0000, 1'b1, 1'b0, 4'b0000, 2'd1, 1'b1};
    tbl[13] = '{4'b0000, 4'b0000, 1'b0, 1'b0, 4'b0000, 2'd1, 1'b0};
    tbl[14] = '{4'b0001, 4'b0000, 1'b0, 1'b1, 4'b0000, 2'd0, 1'b1};
    tbl[15] = '{4'b0000, 4'b0000, 1'b1, 1'b0, 4'b0000, 2'd0, 1'b1};
    tbl[16] = '{4'b0000, 4'b0000, 1'b0, 1'b0, 4'b0000, 2'd0, 1'b0};
    #12 rst = 1'b0;
    @(posedge clk);
    #1;
    chk("reset_state", {bus.hold, bus.gnt, bus.owner, bus.busy, bus.err}, 9'b0);
    for (int i = 0; i < 17; i++) begin
      bus.req = tbl[i].req;
      bus.done = tbl[i].done;
      bus.hlda = tbl[i].hlda;
      step(1);
      chk($sformatf("vec%0d", i), {bus.hold, bus.gnt, bus.owner, bus.busy, bus.err},
          {tbl[i].hold, tbl[i].gnt, tbl[i].owner, tbl[i].busy, 1'b0});
    end
    bus.done = '0;
    rst = 1'b1;
    #2 rst = 1'b0;
    step(1);
    bus.req = 4'b1111;
    grant_cycle(2'd0);
    grant_cycle(2'd1);
    grant_cycle(2'd2);
    grant_cycle(2'd3);
    grant_cycle(2'd0);
    bus.req = 4'b1100;
    step(1);
    chk("ten_owner", {bus.hold, bus.owner}, {1'b1, 2'd2});
    bus.hlda = 1'b1;
    step(1);
    chk("ten_gnt", bus.gnt, 4'b0100);
    cnt = 0;
    while (bus.gnt == 4'b0100 && cnt < 40) begin
      cnt++;
      step(1);
    end
    chk("ten_len", cnt, 16);
    chk("ten_drop", {bus.gnt, bus.hold, bus.err}, 6'b0);
    bus.hlda = 1'b0;
    step(1);
    chk("ten_idle", {bus.busy, bus.hold}, 2'b0);
    step(1);
    chk("next_owner3", {bus.hold, bus.owner}, {1'b1, 2'd3});
    bus.hlda = 1'b1;
    step(1);
    chk("gnt3", bus.gnt, 4'b1000);
    step(1);
    bus.hlda = 1'b0;
    step(1);
    chk("abort", {bus.gnt, bus.hold, bus.err}, {4'b0000, 1'b0, 1'b1});
    bus.req = 4'b0000;
    step(1);
    chk("abort_after", {bus.err, bus.busy}, 2'b0);
    bus.req = 4'b0001;
    step(1);
    chk("to_start", {bus.hold, bus.owner}, {1'b1, 2'd0});
    cnt = 0;
    gnt_seen = 1'b0;
    while (!bus.err && cnt < 100) begin
      step(1);
      cnt++;
      gnt_seen = gnt_seen | (|bus.gnt);
    end
    chk("to_cycles", cnt, 64);
    chk("to_outputs", {bus.hold, bus.gnt, gnt_seen}, 6'b0);
    bus.req = 4'b0000;
    step(1);
    chk("to_once", {bus.err, bus.busy, bus.hold}, 3'b0);
    bus.req = 4'b1111;
    step(1);
    bus.hlda = 1'b1;
    step(1);
    chk("pre_rst_gnt", {bus.gnt, bus.owner}, {4'b0010, 2'd1});
    step(1);
    #3 rst = 1'b1;
    #1;
    chk("async_rst", {bus.gnt, bus.hold, bus.busy, bus.owner}, 8'b0);
    #2 rst = 1'b0;
    bus.hlda = 1'b0;
    step(1);
    chk("rst_first", {bus.hold, bus.owner}, {1'b1, 2'd0});
    bus.hlda = 1'b1;
    step(1);
    chk("rst_gnt", bus.gnt, 4'b0001);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
